// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared definitions for the LCD command arbiter slice.
//   Opcode constants understood by the image controller, the issue FSM
//   state encoding, and default sizing for the arbiter queues/watchdog.
package lcd_pkg;

   // Image controller opcodes (4-bit). The arbiter passes them through
   // untouched; they are listed here so requesters share one encoding.
   localparam logic [3:0] WRITE    = 4'd0;
   localparam logic [3:0] READ     = 4'd1;
   localparam logic [3:0] CLEAR    = 4'd2;
   localparam logic [3:0] FILL     = 4'd3;
   localparam logic [3:0] SCROLL_X = 4'd4;
   localparam logic [3:0] SCROLL_Y = 4'd5;
   localparam logic [3:0] ROTATE   = 4'd6;
   localparam logic [3:0] INVERT   = 4'd7;
   localparam logic [3:0] BLIT     = 4'd8;
   localparam logic [3:0] SET_WIN  = 4'd9;
   localparam logic [3:0] MIRROR_X = 4'd10;
   localparam logic [3:0] MIRROR_Y = 4'd11;

   // Issue FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } arb_state_e;

   localparam int LCD_FIFO_DEPTH = 4;
   localparam int LCD_TIMEOUT    = 255;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo -- 4-bit synchronous FIFO holding one requester's opcodes.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   push, din  : write din when push and not full
//   pop        : drop head when pop and not empty
//   dout       : current head entry (valid when count != 0)
//   count      : registered occupancy, 0..DEPTH
module lcd_cmd_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = LCD_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [3:0]               din,
   input  logic                     pop,
   output logic [3:0]               dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0][3:0] mem_q, mem_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_ok, pop_ok;

   assign push_ok = push && (count_q != CW'(DEPTH));
   assign pop_ok  = pop  && (count_q != '0);

   // DEPTH is a power of two, so pointers wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter -- two-port command arbiter in front of the LCD image
// controller. Each port has its own queue; one command at a time is issued
// and tracked through the controller's busy handshake before the next.
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   pX_cmd/valid/ready    : per-port opcode push interface
//   pX_ack                : pulse when that port's command completed
//   pX_wdone              : controller 'done' routed to the current owner
//   cmd, cmd_valid        : registered opcode and one-cycle issue strobe
//   busy, done            : image controller status
//   owner                 : port owning the in-flight command
//   timeout_err           : sticky watchdog error
// Build option: define LCD_ARB_TIMEOUT_EN to enable the busy watchdog;
// without it timeout_err is 0 and the FSM waits on busy indefinitely.
module lcd_cmd_arbiter
   import lcd_pkg::*;
#(
   parameter int FIFO_DEPTH = LCD_FIFO_DEPTH,
   parameter int TIMEOUT    = LCD_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] p0_cmd,
   input  logic       p0_valid,
   output logic       p0_ready,
   output logic       p0_ack,
   output logic       p0_wdone,
   input  logic [3:0] p1_cmd,
   input  logic       p1_valid,
   output logic       p1_ready,
   output logic       p1_ack,
   output logic       p1_wdone,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   input  logic       busy,
   input  logic       done,
   output logic       owner,
   output logic       timeout_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("lcd_cmd_arbiter: TIMEOUT must fit the 8-bit watchdog (1..255)");
   end

   arb_state_e       state_q, state_d;
   logic [3:0]       cmd_q, cmd_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic [1:0][3:0]  head;
   logic [CW-1:0]    cnt0, cnt1;
   logic [1:0]       empty, push, pop;
   logic             grant;
   logic             wd_hit;
   logic             complete;

   // ---------------- queues ----------------
   assign p0_ready = cnt0 < CW'(FIFO_DEPTH);
   assign p1_ready = cnt1 < CW'(FIFO_DEPTH);
   assign push     = {p1_valid && p1_ready, p0_valid && p0_ready};
   assign empty    = {cnt1 == '0, cnt0 == '0};

   lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
      .clk   (clk),
      .reset (reset),
      .push  (push[0]),
      .din   (p0_cmd),
      .pop   (pop[0]),
      .dout  (head[0]),
      .count (cnt0)
   );

   lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk   (clk),
      .reset (reset),
      .push  (push[1]),
      .din   (p1_cmd),
      .pop   (pop[1]),
      .dout  (head[1]),
      .count (cnt1)
   );

   // ---------------- watchdog ----------------
`ifdef LCD_ARB_TIMEOUT_EN
   logic [7:0] wd_cnt_q, wd_cnt_d;
   logic       timeout_err_q, timeout_err_d;

   assign wd_hit = (state_q == WAIT_HI || state_q == WAIT_LO) &&
                   (wd_cnt_q == 8'(TIMEOUT));

   // Cleared while in ISSUE so it enters WAIT_HI at zero.
   always_comb begin
      wd_cnt_d      = wd_cnt_q;
      timeout_err_d = timeout_err_q | wd_hit;
      if (state_q == ISSUE) begin
         wd_cnt_d = '0;
      end else if (state_q == WAIT_HI || state_q == WAIT_LO) begin
         wd_cnt_d = wd_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign wd_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Command retires on the busy falling edge, or on watchdog expiry.
   assign complete = ((state_q == WAIT_LO) && !busy) || wd_hit;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         cmd_valid_q  <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         cmd_valid_q  <= cmd_valid_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      pop          = '0;
      grant        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!busy && (empty != 2'b11)) begin
               // Tie goes to the port that did not win last time.
               if (empty == 2'b00) grant = ~last_grant_q;
               else                grant = empty[0];
               pop[grant] = 1'b1;
               cmd_d      = head[grant];
               owner_d    = grant;
               state_d    = ISSUE;
            end
         end
         ISSUE:   state_d = WAIT_HI;
         WAIT_HI: if (busy) state_d = WAIT_LO;
         WAIT_LO: ;
         default: state_d = IDLE;
      endcase
      if (complete) begin
         state_d      = IDLE;
         last_grant_d = owner_q;
      end
      cmd_valid_d = (state_d == ISSUE);
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      p0_ack = 1'b0;
      p1_ack = 1'b0;
      if (complete) begin
         if (owner_q) p1_ack = 1'b1;
         else         p0_ack = 1'b1;
      end
   end

   assign p0_wdone  = done && !owner_q;
   assign p1_wdone  = done &&  owner_q;
   assign cmd       = cmd_q;
   assign cmd_valid = cmd_valid_q;
   assign owner     = owner_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb_lcd_cmd_arbiter -- directed self-checking bench for lcd_cmd_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_lcd_cmd_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] p0_cmd, p1_cmd;
   logic       p0_valid, p1_valid;
   logic       p0_ready, p1_ready, p0_ack, p1_ack, p0_wdone, p1_wdone;
   logic [3:0] cmd;
   logic       cmd_valid, busy, done, owner, timeout_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lcd_cmd_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .p0_cmd     (p0_cmd),
      .p0_valid   (p0_valid),
      .p0_ready   (p0_ready),
      .p0_ack     (p0_ack),
      .p0_wdone   (p0_wdone),
      .p1_cmd     (p1_cmd),
      .p1_valid   (p1_valid),
      .p1_ready   (p1_ready),
      .p1_ack     (p1_ack),
      .p1_wdone   (p1_wdone),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .busy       (busy),
      .done       (done),
      .owner      (owner),
      .timeout_err(timeout_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      p0_cmd = '0; p1_cmd = '0; p0_valid = 1'b0; p1_valid = 1'b0;
      busy = 1'b0; done = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Returns at the falling edge of the issue cycle when ok=1.
   task automatic wait_issue(input int max, output bit ok, output logic [3:0] c, output logic o);
      ok = 1'b0; c = 'x; o = 'x;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) begin ok = 1'b1; c = cmd; o = owner; end
      end
   endtask

   // From the issue cycle: controller goes busy for hi cycles, then drops
   // busy; the acks seen in the completing cycle are returned.
   task automatic finish_cmd(input int hi, output logic a0, output logic a1);
      cyc(); busy = 1'b1;
      repeat (hi) cyc();
      busy = 1'b0;
      @(negedge clk);
      a0 = p0_ack; a1 = p1_ack;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      p0_cmd = '0; p1_cmd = '0; p0_valid = 1'b0; p1_valid = 1'b0;
      busy = 1'b0; done = 1'b0;
      @(negedge clk);
      checks++; if (cmd !== 4'h0) begin failures++; $display("FAIL rst_cmd got=%0h exp=0", cmd); end
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid got=%b exp=0", cmd_valid); end
      checks++; if (owner !== 1'b0) begin failures++; $display("FAIL rst_owner got=%b exp=0", owner); end
      checks++; if ({p1_ready, p0_ready} !== 2'b11) begin failures++; $display("FAIL rst_ready got=%b exp=11", {p1_ready, p0_ready}); end
      checks++; if ({p1_ack, p0_ack} !== 2'b00) begin failures++; $display("FAIL rst_ack got=%b exp=00", {p1_ack, p0_ack}); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
      do_reset();
      repeat (4) @(negedge clk);
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_issue got=%b exp=0", cmd_valid); end
   endtask

   task automatic test_single();
      bit seen;
      logic a0, a1;
      do_reset();
      busy = 1'b1;
      seen = 1'b0;
      repeat (64) begin @(negedge clk); if (cmd_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL single_no_issue_busy got=%b exp=0", seen); end
      cyc(); busy = 1'b0; p0_valid = 1'b1; p0_cmd = 4'h1;
      cyc(); p0_valid = 1'b0;
      @(negedge clk);
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL single_early_issue got=%b exp=0", cmd_valid); end
      @(negedge clk);
      checks++; if ({cmd_valid, cmd, owner} !== {1'b1, 4'h1, 1'b0}) begin failures++; $display("FAIL single_issue got v=%b c=%0h o=%b exp v=1 c=1 o=0", cmd_valid, cmd, owner); end
      finish_cmd(3, a0, a1);
      checks++; if ({a1, a0} !== 2'b01) begin failures++; $display("FAIL single_ack got=%b exp=01", {a1, a0}); end
      @(negedge clk);
      checks++; if ({p0_ack, cmd_valid, cmd} !== {1'b0, 1'b0, 4'h1}) begin failures++; $display("FAIL single_after got ack=%b v=%b c=%0h exp ack=0 v=0 c=1", p0_ack, cmd_valid, cmd); end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [3:0] c;
      logic o, a0, a1;
      logic [3:0] exp_c [3] = '{4'h5, 4'h9, 4'h6};
      logic       exp_o [3] = '{1'b0, 1'b1, 1'b0};
      do_reset();
      cyc(); p0_valid = 1'b1; p0_cmd = 4'h5; p1_valid = 1'b1; p1_cmd = 4'h9;
      // 6 is pushed while 5 is being popped from the same queue.
      cyc(); p0_cmd = 4'h6; p1_valid = 1'b0;
      cyc(); p0_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_issue(12, ok, c, o);
         checks++; if ({ok, c, o} !== {1'b1, exp_c[k], exp_o[k]}) begin failures++; $display("FAIL rr_issue%0d got ok=%b c=%0h o=%b exp ok=1 c=%0h o=%b", k, ok, c, o, exp_c[k], exp_o[k]); end
         finish_cmd(2, a0, a1);
         checks++; if ({a1, a0} !== {exp_o[k], ~exp_o[k]}) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", k, {a1, a0}, {exp_o[k], ~exp_o[k]}); end
      end
   endtask

   task automatic test_full();
      bit ok, seen;
      logic [3:0] c;
      logic o, a0, a1;
      logic [4:0] rdy;
      do_reset();
      busy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         p1_valid = 1'b1; p1_cmd = 4'(k + 1);
         @(negedge clk); rdy[k] = p1_ready;
         cyc();
      end
      checks++; if (rdy !== 5'b01111) begin failures++; $display("FAIL full_ready_seq got=%b exp=01111", rdy); end
      seen = 1'b0;
      repeat (3) begin @(negedge clk); if (p1_ready || cmd_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL full_hold got=%b exp=0", seen); end
      cyc(); p1_valid = 1'b0; busy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_issue(12, ok, c, o);
         checks++; if ({ok, c, o} !== {1'b1, 4'(k + 1), 1'b1}) begin failures++; $display("FAIL full_issue%0d got ok=%b c=%0h o=%b exp ok=1 c=%0h o=1", k, ok, c, o, k + 1); end
         finish_cmd(2, a0, a1);
         checks++; if ({a1, a0} !== 2'b10) begin failures++; $display("FAIL full_ack%0d got=%b exp=10", k, {a1, a0}); end
      end
      wait_issue(12, ok, c, o);
      checks++; if (ok !== 1'b0) begin failures++; $display("FAIL full_fifth_dropped got=%b exp=0", ok); end
      checks++; if (p1_ready !== 1'b1) begin failures++; $display("FAIL full_ready_end got=%b exp=1", p1_ready); end
   endtask

   task automatic test_wdone();
      bit ok, seen;
      logic [3:0] c;
      logic o;
      do_reset();
      cyc(); p0_valid = 1'b1; p0_cmd = 4'h0;
      cyc(); p0_valid = 1'b0;
      wait_issue(12, ok, c, o);
      checks++; if ({ok, c, o} !== {1'b1, 4'h0, 1'b0}) begin failures++; $display("FAIL wdone_issue got ok=%b c=%0h o=%b exp ok=1 c=0 o=0", ok, c, o); end
      cyc(); busy = 1'b1;
      seen = 1'b0;
      repeat (64) begin @(negedge clk); if (p0_wdone || p1_wdone || p0_ack) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL wdone_early got=%b exp=0", seen); end
      cyc(); done = 1'b1;
      @(negedge clk);
      checks++; if ({p1_wdone, p0_wdone} !== 2'b01) begin failures++; $display("FAIL wdone_route got=%b exp=01", {p1_wdone, p0_wdone}); end
      cyc(); done = 1'b0; busy = 1'b0;
      @(negedge clk);
      checks++; if ({p0_ack, p0_wdone} !== 2'b10) begin failures++; $display("FAIL wdone_ack got ack=%b wdone=%b exp ack=1 wdone=0", p0_ack, p0_wdone); end
   endtask

   task automatic test_timeout();
      bit ok, early;
      logic [3:0] c;
      logic o, a0;
      do_reset();
      cyc(); p0_valid = 1'b1; p0_cmd = 4'h7;
      cyc(); p0_cmd = 4'h8;
      cyc(); p0_valid = 1'b0;
      wait_issue(12, ok, c, o);
      checks++; if ({ok, c, o} !== {1'b1, 4'h7, 1'b0}) begin failures++; $display("FAIL to_issue got ok=%b c=%0h o=%b exp ok=1 c=7 o=0", ok, c, o); end
      cyc(); busy = 1'b1;
`ifdef LCD_ARB_TIMEOUT_EN
      early = 1'b0;
      for (int n = 0; n < 255; n++) begin @(negedge clk); if (p0_ack || timeout_err) early = 1'b1; end
      @(negedge clk); a0 = p0_ack;
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", early); end
      checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL to_ack got=%b exp=1", a0); end
      @(negedge clk);
      checks++; if ({timeout_err, cmd_valid, p0_ack} !== 3'b100) begin failures++; $display("FAIL to_err got err=%b v=%b ack=%b exp err=1 v=0 ack=0", timeout_err, cmd_valid, p0_ack); end
      cyc(); busy = 1'b0;
      wait_issue(12, ok, c, o);
      checks++; if ({ok, c, o, timeout_err} !== {1'b1, 4'h8, 1'b0, 1'b1}) begin failures++; $display("FAIL to_next got ok=%b c=%0h o=%b err=%b exp ok=1 c=8 o=0 err=1", ok, c, o, timeout_err); end
`else
      early = 1'b0;
      repeat (300) begin @(negedge clk); if (p0_ack || p1_ack || timeout_err || cmd_valid) early = 1'b1; end
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_wait_forever got=%b exp=0", early); end
      cyc(); busy = 1'b0;
      @(negedge clk); a0 = p0_ack;
      checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL to_late_ack got=%b exp=1", a0); end
      wait_issue(12, ok, c, o);
      checks++; if ({ok, c, o} !== {1'b1, 4'h8, 1'b0}) begin failures++; $display("FAIL to_next got ok=%b c=%0h o=%b exp ok=1 c=8 o=0", ok, c, o); end
`endif
   endtask

   task automatic test_reset_mid();
      bit ok, seen;
      logic [3:0] c;
      logic o;
      do_reset();
      cyc(); p0_valid = 1'b1; p0_cmd = 4'h3; p1_valid = 1'b1; p1_cmd = 4'hA;
      cyc(); p0_cmd = 4'h4; p1_valid = 1'b0;
      cyc(); p0_valid = 1'b0;
      wait_issue(12, ok, c, o);
      checks++; if ({ok, c} !== {1'b1, 4'h3}) begin failures++; $display("FAIL mid_issue got ok=%b c=%0h exp ok=1 c=3", ok, c); end
      cyc(); busy = 1'b1;
      cyc(); cyc();
      // Busy falls in the same cycle reset hits: without reset this is an ack.
      busy = 1'b0; reset = 1'b1;
      @(negedge clk);
      checks++; if ({p1_ack, p0_ack, cmd_valid, cmd, owner, timeout_err} !== 9'b0) begin failures++; $display("FAIL mid_reset_outs got ack=%b%b v=%b c=%0h o=%b err=%b exp all 0", p1_ack, p0_ack, cmd_valid, cmd, owner, timeout_err); end
      cyc(); reset = 1'b0;
      seen = 1'b0;
      repeat (20) begin @(negedge clk); if (cmd_valid || p0_ack || p1_ack) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_abandon got=%b exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_wdone();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
